sync_fifo_fwft: RTL and testbench



---
 rtl/sync_fifo_fwft.sv | 124 ++++++++++++
 tb/tb_sync_fifo_fwft.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with level, threshold flags, sticky errors and flush.
// OUTREG=1 presents the head from a registered memory read so storage can map to block RAM.
module sync_fifo_fwft #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRWIDTH    = 4,
  parameter int OUTREG       = 0,
  parameter int AFULL_LEVEL  = (1 << ADDRWIDTH) - 2,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDRWIDTH:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] FULL_LVL = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] ONE      = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRWIDTH:0] AF_LVL   = AFULL_LEVEL[ADDRWIDTH:0];
  localparam logic [ADDRWIDTH:0] AE_LVL   = AEMPTY_LEVEL[ADDRWIDTH:0];

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH:0]   wr_ptr;
  logic [ADDRWIDTH:0]   rd_ptr;
  logic [ADDRWIDTH:0]   level_nxt;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 mem_pop;

  assign wr_acc = wr_en && !full && !clear;
  assign rd_acc = rd_en && !empty && !clear;

  always_comb begin
    level_nxt = level;
    if (clear)
      level_nxt = '0;
    else if (wr_acc && !rd_acc)
      level_nxt = level + ONE;
    else if (rd_acc && !wr_acc)
      level_nxt = level - ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr[ADDRWIDTH-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= (AF_LVL == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      // Flags track next-state level so they line up with level itself.
      level        <= level_nxt;
      full         <= (level_nxt == FULL_LVL);
      almost_full  <= (level_nxt >= AF_LVL);
      almost_empty <= (level_nxt <= AE_LVL);
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc)
          wr_ptr <= wr_ptr + ONE;
        if (mem_pop)
          rd_ptr <= rd_ptr + ONE;
        if (wr_en && full)
          overflow <= 1'b1;
        if (rd_en && empty)
          underflow <= 1'b1;
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic                 out_vld;
    logic [DATAWIDTH-1:0] out_dat;
    logic                 load;

    // Refill the stage whenever it is free or being popped and memory has an older entry;
    // rd_ptr is sampled at the edge, which is exactly a registered block-RAM read.
    assign load = !clear && (!out_vld || rd_acc) && (wr_ptr != rd_ptr);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_vld <= 1'b0;
        out_dat <= '0;
      end else if (clear) begin
        out_vld <= 1'b0;
      end else if (load) begin
        out_vld <= 1'b1;
        out_dat <= mem[rd_ptr[ADDRWIDTH-1:0]];
      end else if (rd_acc) begin
        out_vld <= 1'b0;
      end
    end

    assign mem_pop = load;
    assign rdata   = out_dat;
    assign empty   = !out_vld;
  end else begin : g_comb
    assign mem_pop = rd_acc;
    assign rdata   = mem[rd_ptr[ADDRWIDTH-1:0]];
    assign empty   = (level == '0);
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives an OUTREG=0 and an OUTREG=1 instance with identical stimulus and checks both
// against a timestamped-entry list model of FIFO contents and head visibility.
module tb_sync_fifo_fwft;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, clear, wr_en, rd_en;
  logic [7:0] wdata;

  logic [7:0] rdata [2];
  logic [4:0] level [2];
  logic       empty [2], full [2], almost_full [2], almost_empty [2], overflow [2], underflow [2];

  sync_fifo_fwft #(.DATAWIDTH(8), .ADDRWIDTH(4), .OUTREG(0), .AFULL_LEVEL(14), .AEMPTY_LEVEL(1)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata[0]), .empty(empty[0]), .full(full[0]), .almost_full(almost_full[0]),
    .almost_empty(almost_empty[0]), .level(level[0]), .overflow(overflow[0]), .underflow(underflow[0]));

  sync_fifo_fwft #(.DATAWIDTH(8), .ADDRWIDTH(4), .OUTREG(1), .AFULL_LEVEL(14), .AEMPTY_LEVEL(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata[1]), .empty(empty[1]), .full(full[1]), .almost_full(almost_full[1]),
    .almost_empty(almost_empty[1]), .level(level[1]), .overflow(overflow[1]), .underflow(underflow[1]));

  always #5 clk = ~clk;

  // Reference: ordered entries with the edge number each was written on. The head is
  // visible with OUTREG=0 as soon as it exists; with OUTREG=1 only once it was written
  // on an earlier edge than the most recent one.
  logic [7:0] md [2][DEPTH];
  int         mw [2][DEPTH];
  int         hd [2], cnt [2];
  bit         vis [2], ovf [2], unf [2];
  int         ecnt = 0;

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; hd[m] = 0; vis[m] = 1'b0; ovf[m] = 1'b0; unf[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit wacc, racc;
    int slot;
    ecnt++;
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        cnt[m] = 0; hd[m] = 0; ovf[m] = 1'b0; unf[m] = 1'b0;
      end else begin
        wacc = wr_en && (cnt[m] != DEPTH);
        racc = rd_en && vis[m];
        if (wr_en && cnt[m] == DEPTH) ovf[m] = 1'b1;
        if (rd_en && !vis[m]) unf[m] = 1'b1;
        slot = (hd[m] + cnt[m]) % DEPTH;
        if (racc) begin
          hd[m] = (hd[m] + 1) % DEPTH;
          cnt[m]--;
        end
        if (wacc) begin
          md[m][slot] = wdata;
          mw[m][slot] = ecnt;
          cnt[m]++;
        end
      end
      vis[m] = (cnt[m] > 0) && (m == 0 || mw[m][hd[m]] < ecnt);
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_level", tag, m), 32'(level[m]), 32'(cnt[m]));
      chk($sformatf("%s_m%0d_empty", tag, m), 32'(empty[m]), 32'(!vis[m]));
      chk($sformatf("%s_m%0d_full", tag, m), 32'(full[m]), 32'(cnt[m] == DEPTH));
      chk($sformatf("%s_m%0d_afull", tag, m), 32'(almost_full[m]), 32'(cnt[m] >= 14));
      chk($sformatf("%s_m%0d_aempty", tag, m), 32'(almost_empty[m]), 32'(cnt[m] <= 1));
      chk($sformatf("%s_m%0d_ovf", tag, m), 32'(overflow[m]), 32'(ovf[m]));
      chk($sformatf("%s_m%0d_unf", tag, m), 32'(underflow[m]), 32'(unf[m]));
      if (vis[m])
        chk($sformatf("%s_m%0d_rdata", tag, m), 32'(rdata[m]), 32'(md[m][hd[m]]));
    end
  endtask

  task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d, input string tag);
    clear = c; wr_en = w; rd_en = r; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    model_reset();
    #2;
    check_all("rst");
    chk("rst_m1_rdata", 32'(rdata[1]), 32'h0);
    #6 reset = 1'b0;

    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i), "fill");
    step(1'b0, 1'b1, 1'b0, 8'hEE, "ovf");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "drain");
    step(1'b0, 1'b0, 1'b1, 8'h00, "unf");
    step(1'b0, 1'b1, 1'b0, 8'h42, "sticky_wr");
    step(1'b0, 1'b0, 1'b0, 8'h00, "sticky_idle");
    step(1'b1, 1'b0, 1'b0, 8'h00, "clr_flags");

    step(1'b0, 1'b1, 1'b0, 8'hA5, "a5_wr");
    step(1'b0, 1'b0, 1'b0, 8'h00, "a5_k1");
    step(1'b0, 1'b0, 1'b1, 8'h00, "a5_pop");
    step(1'b0, 1'b0, 1'b0, 8'h00, "a5_idle");

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom), "pre8");
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom), "steady");

    step(1'b1, 1'b0, 1'b0, 8'h00, "clr_a");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom), "pre5");
    step(1'b1, 1'b1, 1'b1, 8'h77, "clr_busy");
    step(1'b0, 1'b1, 1'b0, 8'h99, "post_clr_wr");
    step(1'b0, 1'b0, 1'b0, 8'h00, "post_clr_idle");
    step(1'b0, 1'b0, 1'b1, 8'h00, "post_clr_pop");

    step(1'b1, 1'b0, 1'b0, 8'h00, "clr_b");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom), "pre7");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    chk("arst_m1_rdata", 32'(rdata[1]), 32'h0);
    wr_en = 1'b0; rd_en = 1'b0;
    #1 reset = 1'b0;
    step(1'b0, 1'b1, 1'b0, 8'h3C, "post_rst_wr");
    step(1'b0, 1'b0, 1'b0, 8'h00, "post_rst_idle");
    step(1'b0, 1'b0, 1'b1, 8'h00, "post_rst_pop");

    for (int p = 0; p < 3; p++) begin
      int wp, rp;
      wp = (p == 0) ? 80 : (p == 1) ? 30 : 55;
      rp = (p == 0) ? 30 : (p == 1) ? 80 : 55;
      for (int i = 0; i < 150; i++)
        step(1'($urandom_range(39) == 0), 1'($urandom_range(99) < wp),
             1'($urandom_range(99) < rp), 8'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
